// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of the multi-cycle MIPS datapath. Sequences fetch,
//   decode, execute, memory and write-back, drives every datapath enable and
//   the 2-bit ALUop consumed by the downstream ALU control stage, and retires
//   JR inside the R-type execute state using ALU control's jr flag.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   op             IR[31:26], stable from DECODE until the next FETCH
//   jr             ALU control says "this R-type is JR" (valid with ALUop=10)
//   mem_ready      memory access completes this cycle
//   PCWrite        unconditional PC load
//   PCWriteCond    PC load if ALU Zero (beq)
//   PCWriteCondNE  PC load if ALU not Zero (bne)
//   IorD           memory address select: 0=PC, 1=ALUOut
//   MemRead        memory read strobe
//   MemWrite       memory write strobe
//   IRWrite        IR load
//   MemtoReg       write-back source: 00=ALUOut, 01=MDR, 10=PC
//   RegDst         destination register: 00=rt, 01=rd, 10=r31
//   RegWrite       register file write
//   ALUSrcA        ALU A operand: 0=PC, 1=A
//   ALUSrcB        ALU B operand: 00=B, 01=4, 10=imm, 11=imm<<2
//   ALUop          00=add, 01=sub, 10=use funct
//   PCSource       00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr)
//   illegal        one-cycle pulse on an unsupported opcode
//   state          current state (debug)
//   instr_cnt      retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int          CNT_W   = 32,
    parameter logic [5:0]  OP_ADDI = 6'b001000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             jr,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCWriteCondNE,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXE    = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_I_EXE    = 4'd11;
    localparam logic [3:0] S_I_WB     = 4'd12;
    localparam logic [3:0] S_ILLEGAL  = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             retire_s;

    // Raw (un-gated) strobes; reset masking is applied at the port.
    logic pcwrite_s;
    logic pcwritecond_s;
    logic pcwritecondne_s;
    logic memread_s;
    logic memwrite_s;
    logic irwrite_s;
    logic regwrite_s;
    logic illegal_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:    next_state_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:    next_state_s = S_MEM_ADDR;
                    OP_RTYPE:        next_state_s = S_R_EXE;
                    OP_BEQ, OP_BNE:  next_state_s = S_BRANCH;
                    OP_J:            next_state_s = S_JUMP;
                    OP_JAL:          next_state_s = S_JAL;
                    OP_ADDI:         next_state_s = S_I_EXE;
                    default:         next_state_s = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: next_state_s = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   next_state_s = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   next_state_s = S_FETCH;
            S_MEM_WR:   next_state_s = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXE:    next_state_s = jr ? S_FETCH : S_R_WB;
            S_R_WB:     next_state_s = S_FETCH;
            S_BRANCH:   next_state_s = S_FETCH;
            S_JUMP:     next_state_s = S_FETCH;
            S_JAL:      next_state_s = S_FETCH;
            S_I_EXE:    next_state_s = S_I_WB;
            S_I_WB:     next_state_s = S_FETCH;
            S_ILLEGAL:  next_state_s = S_FETCH;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Output decode: Moore from state, except mem_ready in FETCH and jr in R_EXE.
    always_comb begin
        pcwrite_s       = 1'b0;
        pcwritecond_s   = 1'b0;
        pcwritecondne_s = 1'b0;
        memread_s       = 1'b0;
        memwrite_s      = 1'b0;
        irwrite_s       = 1'b0;
        regwrite_s      = 1'b0;
        illegal_s       = 1'b0;
        IorD            = 1'b0;
        MemtoReg        = 2'b00;
        RegDst          = 2'b00;
        ALUSrcA         = 1'b0;
        ALUSrcB         = 2'b00;
        ALUop           = 2'b00;
        PCSource        = 2'b00;
        case (state_r)
            S_FETCH: begin
                memread_s = 1'b1;
                ALUSrcB   = 2'b01;
                irwrite_s = mem_ready;
                pcwrite_s = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                memread_s = 1'b1;
                IorD      = 1'b1;
            end
            S_MEM_WB: begin
                regwrite_s = 1'b1;
                MemtoReg   = 2'b01;
            end
            S_MEM_WR: begin
                memwrite_s = 1'b1;
                IorD       = 1'b1;
            end
            S_R_EXE: begin
                ALUSrcA   = 1'b1;
                ALUop     = 2'b10;
                pcwrite_s = jr;
                PCSource  = jr ? 2'b11 : 2'b00;
            end
            S_R_WB: begin
                regwrite_s = 1'b1;
                RegDst     = 2'b01;
            end
            S_BRANCH: begin
                ALUSrcA         = 1'b1;
                ALUop           = 2'b01;
                PCSource        = 2'b01;
                pcwritecond_s   = ~op[0];
                pcwritecondne_s = op[0];
            end
            S_JUMP: begin
                pcwrite_s = 1'b1;
                PCSource  = 2'b10;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value.
                pcwrite_s  = 1'b1;
                PCSource   = 2'b10;
                regwrite_s = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
            end
            S_I_EXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_I_WB: begin
                regwrite_s = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    // An instruction retires on the last cycle of its sequence; FETCH
    // self-loops, ILLEGAL and the unused codes never count.
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_JAL, S_I_WB: retire_s = 1'b1;
            S_MEM_WR: retire_s = mem_ready;
            S_R_EXE:  retire_s = jr;
            default:  retire_s = 1'b0;
        endcase
    end

    // Retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Reset masks every strobe so an aborted instruction cannot write anything;
    // the mux selects keep following the current state.
    assign PCWrite       = pcwrite_s       & ~rst;
    assign PCWriteCond   = pcwritecond_s   & ~rst;
    assign PCWriteCondNE = pcwritecondne_s & ~rst;
    assign MemRead       = memread_s       & ~rst;
    assign MemWrite      = memwrite_s      & ~rst;
    assign IRWrite       = irwrite_s       & ~rst;
    assign RegWrite      = regwrite_s      & ~rst;
    assign illegal       = illegal_s       & ~rst;
    assign state         = state_r;
    assign instr_cnt     = cnt_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed, table-driven bench for multicycle_ctrl. Each table record holds
//   the inputs for one clock cycle and the state, control word and
//   instruction count expected during that cycle. Hand-written sequences
//   cover a completing store and counter wrap (DUT built with CNT_W=4).
//
//   Control word bit order (MSB..LSB):
//     PCWrite PCWriteCond PCWriteCondNE IorD MemRead MemWrite IRWrite |
//     MemtoReg[1:0] | RegDst[1:0] | RegWrite ALUSrcA | ALUSrcB[1:0] |
//     ALUop[1:0] | PCSource[1:0] | illegal
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int CW = 4;

    // Expected control words, written field by field from the state table.
    localparam logic [19:0] C_RST_FETCH = 20'b0000000_00_00_00_01_00_00_0;
    localparam logic [19:0] C_RST_MEMWR = 20'b0001000_00_00_00_00_00_00_0;
    localparam logic [19:0] C_FETCH_W   = 20'b0000100_00_00_00_01_00_00_0;
    localparam logic [19:0] C_FETCH_R   = 20'b1000101_00_00_00_01_00_00_0;
    localparam logic [19:0] C_DECODE    = 20'b0000000_00_00_00_11_00_00_0;
    localparam logic [19:0] C_MEM_ADDR  = 20'b0000000_00_00_01_10_00_00_0;
    localparam logic [19:0] C_MEM_RD    = 20'b0001100_00_00_00_00_00_00_0;
    localparam logic [19:0] C_MEM_WB    = 20'b0000000_01_00_10_00_00_00_0;
    localparam logic [19:0] C_MEM_WR    = 20'b0001010_00_00_00_00_00_00_0;
    localparam logic [19:0] C_R_EXE     = 20'b0000000_00_00_01_00_10_00_0;
    localparam logic [19:0] C_R_EXE_JR  = 20'b1000000_00_00_01_00_10_11_0;
    localparam logic [19:0] C_R_WB      = 20'b0000000_00_01_10_00_00_00_0;
    localparam logic [19:0] C_BEQ       = 20'b0100000_00_00_01_00_01_01_0;
    localparam logic [19:0] C_BNE       = 20'b0010000_00_00_01_00_01_01_0;
    localparam logic [19:0] C_JUMP      = 20'b1000000_00_00_00_00_00_10_0;
    localparam logic [19:0] C_JAL       = 20'b1000000_10_10_10_00_00_10_0;
    localparam logic [19:0] C_I_EXE     = 20'b0000000_00_00_01_10_00_00_0;
    localparam logic [19:0] C_I_WB      = 20'b0000000_00_00_10_00_00_00_0;
    localparam logic [19:0] C_ILLEGAL   = 20'b0000000_00_00_00_00_00_00_1;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] JAL  = 6'b000011;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct {
        logic          rst;
        logic [5:0]    op;
        logic          jr;
        logic          mr;
        logic [3:0]    st;
        logic [19:0]   ctl;
        logic [CW-1:0] cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op;
    logic          jr;
    logic          mem_ready;
    logic          PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead;
    logic          MemWrite, IRWrite, RegWrite, ALUSrcA, illegal;
    logic [1:0]    MemtoReg, RegDst, ALUSrcB, ALUop, PCSource;
    logic [3:0]    state;
    logic [CW-1:0] instr_cnt;
    logic [19:0]   act_ctl;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vq[$];

    multicycle_ctrl #(.CNT_W(CW), .OP_ADDI(6'b001000)) dut (
        .clk(clk), .rst(rst), .op(op), .jr(jr), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCWriteCondNE(PCWriteCondNE), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
        .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
    );

    assign act_ctl = {PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead,
                      MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                      ALUSrcB, ALUop, PCSource, illegal};

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [5:0] o, input logic j,
                       input logic m, input logic [3:0] s,
                       input logic [19:0] c, input logic [CW-1:0] n);
        vec_t v;
        v.rst = r; v.op = o; v.jr = j; v.mr = m;
        v.st = s; v.ctl = c; v.cnt = n;
        vq.push_back(v);
    endtask

    // Drive one cycle of inputs, check mid-cycle, then advance past the edge.
    task automatic cycle(input string tag, input vec_t v);
        rst       = v.rst;
        op        = v.op;
        jr        = v.jr;
        mem_ready = v.mr;
        #4;
        n_cmp++;
        if (state !== v.st) begin
            n_bad++;
            $display("FAIL %s state: got %0d expected %0d", tag, state, v.st);
        end
        n_cmp++;
        if (act_ctl !== v.ctl) begin
            n_bad++;
            $display("FAIL %s ctl: got %b expected %b", tag, act_ctl, v.ctl);
        end
        n_cmp++;
        if (instr_cnt !== v.cnt) begin
            n_bad++;
            $display("FAIL %s instr_cnt: got %0d expected %0d", tag, instr_cnt, v.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hand(input string tag, input logic [5:0] o, input logic j,
                        input logic m, input logic [3:0] s,
                        input logic [19:0] c, input logic [CW-1:0] n);
        vec_t v;
        v.rst = 1'b0; v.op = o; v.jr = j; v.mr = m;
        v.st = s; v.ctl = c; v.cnt = n;
        cycle(tag, v);
    endtask

    initial begin
        // Reset, held while in FETCH: strobes masked, selects still FETCH.
        add(1'b1, RT,   1'b0, 1'b1, 4'd0,  C_RST_FETCH, 4'd0);
        // lw: two wait cycles in FETCH, one in MEM_RD.
        add(1'b0, LW,   1'b0, 1'b0, 4'd0,  C_FETCH_W,   4'd0);
        add(1'b0, LW,   1'b0, 1'b0, 4'd0,  C_FETCH_W,   4'd0);
        add(1'b0, LW,   1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd0);
        add(1'b0, LW,   1'b0, 1'b0, 4'd1,  C_DECODE,    4'd0);
        add(1'b0, LW,   1'b0, 1'b0, 4'd2,  C_MEM_ADDR,  4'd0);
        add(1'b0, LW,   1'b0, 1'b0, 4'd3,  C_MEM_RD,    4'd0);
        add(1'b0, LW,   1'b0, 1'b1, 4'd3,  C_MEM_RD,    4'd0);
        add(1'b0, LW,   1'b0, 1'b0, 4'd4,  C_MEM_WB,    4'd0);
        // R-type add.
        add(1'b0, RT,   1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd1);
        add(1'b0, RT,   1'b0, 1'b1, 4'd1,  C_DECODE,    4'd1);
        add(1'b0, RT,   1'b0, 1'b1, 4'd6,  C_R_EXE,     4'd1);
        add(1'b0, RT,   1'b0, 1'b1, 4'd7,  C_R_WB,      4'd1);
        // jr retires in R_EXE.
        add(1'b0, RT,   1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd2);
        add(1'b0, RT,   1'b0, 1'b1, 4'd1,  C_DECODE,    4'd2);
        add(1'b0, RT,   1'b1, 1'b1, 4'd6,  C_R_EXE_JR,  4'd2);
        // beq, then bne.
        add(1'b0, BEQ,  1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd3);
        add(1'b0, BEQ,  1'b0, 1'b1, 4'd1,  C_DECODE,    4'd3);
        add(1'b0, BEQ,  1'b0, 1'b1, 4'd8,  C_BEQ,       4'd3);
        add(1'b0, BNE,  1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd4);
        add(1'b0, BNE,  1'b0, 1'b1, 4'd1,  C_DECODE,    4'd4);
        add(1'b0, BNE,  1'b0, 1'b1, 4'd8,  C_BNE,       4'd4);
        // jal.
        add(1'b0, JAL,  1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd5);
        add(1'b0, JAL,  1'b0, 1'b1, 4'd1,  C_DECODE,    4'd5);
        add(1'b0, JAL,  1'b0, 1'b1, 4'd10, C_JAL,       4'd5);
        // Unsupported opcode: one illegal pulse, not counted.
        add(1'b0, BAD,  1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd6);
        add(1'b0, BAD,  1'b0, 1'b1, 4'd1,  C_DECODE,    4'd6);
        add(1'b0, BAD,  1'b0, 1'b1, 4'd13, C_ILLEGAL,   4'd6);
        // addi.
        add(1'b0, ADDI, 1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd6);
        add(1'b0, ADDI, 1'b0, 1'b1, 4'd1,  C_DECODE,    4'd6);
        add(1'b0, ADDI, 1'b0, 1'b1, 4'd11, C_I_EXE,     4'd6);
        add(1'b0, ADDI, 1'b0, 1'b1, 4'd12, C_I_WB,      4'd6);
        // j.
        add(1'b0, J,    1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd7);
        add(1'b0, J,    1'b0, 1'b1, 4'd1,  C_DECODE,    4'd7);
        add(1'b0, J,    1'b0, 1'b1, 4'd9,  C_JUMP,      4'd7);
        // sw stalled in MEM_WR, aborted by a one-cycle reset.
        add(1'b0, SW,   1'b0, 1'b0, 4'd0,  C_FETCH_W,   4'd8);
        add(1'b0, SW,   1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd8);
        add(1'b0, SW,   1'b0, 1'b0, 4'd1,  C_DECODE,    4'd8);
        add(1'b0, SW,   1'b0, 1'b0, 4'd2,  C_MEM_ADDR,  4'd8);
        add(1'b0, SW,   1'b0, 1'b0, 4'd5,  C_MEM_WR,    4'd8);
        add(1'b0, SW,   1'b0, 1'b0, 4'd5,  C_MEM_WR,    4'd8);
        add(1'b1, SW,   1'b0, 1'b0, 4'd5,  C_RST_MEMWR, 4'd8);
        add(1'b0, SW,   1'b0, 1'b0, 4'd0,  C_FETCH_W,   4'd0);
        add(1'b0, SW,   1'b0, 1'b1, 4'd0,  C_FETCH_R,   4'd0);

        rst = 1'b1; op = RT; jr = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            cycle($sformatf("vec%0d", i), vq[i]);
        end

        // sw that completes: MEM_WR with mem_ready high retires and counts.
        hand("sw_decode", SW, 1'b0, 1'b1, 4'd1, C_DECODE,   4'd0);
        hand("sw_addr",   SW, 1'b0, 1'b1, 4'd2, C_MEM_ADDR, 4'd0);
        hand("sw_write",  SW, 1'b0, 1'b1, 4'd5, C_MEM_WR,   4'd0);

        // Sixteen jumps wrap the 4-bit counter from 1 back to 1.
        for (int i = 0; i < 16; i++) begin
            logic [CW-1:0] e;
            e = CW'(i + 1);
            hand($sformatf("wrap%0d_fetch", i), J, 1'b0, 1'b1, 4'd0, C_FETCH_R, e);
            hand($sformatf("wrap%0d_dec", i),   J, 1'b0, 1'b1, 4'd1, C_DECODE,  e);
            hand($sformatf("wrap%0d_jump", i),  J, 1'b0, 1'b1, 4'd9, C_JUMP,    e);
        end
        hand("wrap_end", J, 1'b0, 1'b0, 4'd0, C_FETCH_W, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
